// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo/beacon controller: TX FSM states and
// character-level constants.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam logic [UART_DATA_W-1:0] BEACON_DEFAULT = 8'hA7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                   fpga_clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = count_q;

  // Storage carries no reset; only pointers and occupancy are control state.
  always_ff @(posedge fpga_clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge fpga_clock) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_buffered.sv
// UART echo/beacon controller: buffers received bytes, retransmits them in
// order, injects a periodic beacon when idle, keeps drop/TX statistics.
module uart_echo_buffered
  import uart_pkg::*;
#(
  parameter int                DATA_W        = UART_DATA_W,
  parameter int                DEPTH         = 16,
  parameter logic [DATA_W-1:0] BEACON_BYTE   = DATA_W'(BEACON_DEFAULT),
  parameter int                BEACON_PERIOD = 250_000_000,
  parameter int                HB_DIV        = 50_000_000,
  parameter int                CNT_W         = 16
) (
  input  logic                   fpga_clock,
  input  logic                   reset,
  input  logic                   echo_en,
  input  logic                   beacon_en,
  input  logic                   rx_valid,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   rx_frame_err,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count,
  output logic [CNT_W-1:0]       tx_count,
  output logic                   heartbeat
);

  localparam int BW = $clog2(BEACON_PERIOD);
  localparam int HW = $clog2(HB_DIV + 1);
  localparam logic [BW-1:0] BEACON_LAST = BW'(BEACON_PERIOD - 1);
  localparam logic [HW-1:0] HB_LAST     = HW'(HB_DIV - 1);

  tx_state_e         state;
  tx_state_e         state_nxt;
  logic [1:0]        wait_cnt;
  logic [BW-1:0]     beacon_cnt;
  logic [HW-1:0]     hb_cnt;
  logic              beacon_pending;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              rx_take;
  logic              frame_drop;
  logic              ovf_drop;
  logic              beacon_take;
  logic              beacon_wrap;
  logic              tx_done;

  assign rx_take     = rx_valid && echo_en;
  assign frame_drop  = rx_take && rx_frame_err;
  assign fifo_push   = rx_take && !rx_frame_err;
  assign ovf_drop    = fifo_push && fifo_full && !fifo_pop;
  assign fifo_pop    = (state == ST_IDLE) && !fifo_empty;
  assign beacon_take = (state == ST_IDLE) && fifo_empty && beacon_pending;
  assign beacon_wrap = (beacon_cnt == BEACON_LAST);
  // A core that never raises busy within four cycles is treated as having sent.
  assign tx_done     = ((state == ST_WAIT_DONE) && !tx_busy) ||
                       ((state == ST_WAIT_BUSY) && !tx_busy && (wait_cnt == 2'd3));

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .fpga_clock (fpga_clock),
    .reset      (reset),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .din        (rx_data),
    .dout       (fifo_dout),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  always_ff @(posedge fpga_clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (fifo_pop || beacon_take) state_nxt = ST_START;
      ST_START:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy) state_nxt = ST_WAIT_DONE;
                    else if (wait_cnt == 2'd3) state_nxt = ST_IDLE;
      ST_WAIT_DONE: if (!tx_busy) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_start = (state == ST_START);
  end

  always_ff @(posedge fpga_clock) begin
    if (!reset) begin
      wait_cnt       <= '0;
      tx_data        <= '0;
      beacon_pending <= 1'b0;
      overflow       <= 1'b0;
      drop_count     <= '0;
      tx_count       <= '0;
    end else begin
      wait_cnt <= (state == ST_WAIT_BUSY) ? wait_cnt + 2'd1 : 2'd0;
      if (fifo_pop)         tx_data <= fifo_dout;
      else if (beacon_take) tx_data <= BEACON_BYTE;
      // A new wrap wins over a same-cycle take so no tick is lost.
      beacon_pending <= (beacon_pending && !beacon_take) || (beacon_wrap && beacon_en);
      if (ovf_drop) overflow <= 1'b1;
      if ((frame_drop || ovf_drop) && (drop_count != '1))
        drop_count <= drop_count + CNT_W'(1);
      if (tx_done) tx_count <= tx_count + CNT_W'(1);
    end
  end

  always_ff @(posedge fpga_clock) begin
    if (!reset) begin
      beacon_cnt <= '0;
      hb_cnt     <= '0;
      heartbeat  <= 1'b0;
    end else begin
      beacon_cnt <= beacon_wrap ? '0 : beacon_cnt + BW'(1);
      if (hb_cnt == HB_LAST) begin
        hb_cnt    <= '0;
        heartbeat <= !heartbeat;
      end else begin
        hb_cnt <= hb_cnt + HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_buffered.sv
// Bench for uart_echo_buffered: table-driven single-byte cases plus sequences
// for latency, reset, overflow, beacon priority, timeout and counter limits.
module tb_uart_echo_buffered;

  logic       fpga_clock = 1'b0;
  logic       reset = 1'b0;
  logic       echo_en = 1'b1;
  logic       beacon_en = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_frame_err = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [2:0] fifo_count;
  logic       overflow;
  logic [3:0] drop_count;
  logic [3:0] tx_count;
  logic       heartbeat;

  uart_echo_buffered #(
    .DATA_W(8), .DEPTH(4), .BEACON_BYTE(8'hA7), .BEACON_PERIOD(20), .HB_DIV(5), .CNT_W(4)
  ) dut (
    .fpga_clock(fpga_clock), .reset(reset), .echo_en(echo_en), .beacon_en(beacon_en),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_frame_err(rx_frame_err), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .fifo_count(fifo_count), .overflow(overflow),
    .drop_count(drop_count), .tx_count(tx_count), .heartbeat(heartbeat)
  );

  always #5 fpga_clock = ~fpga_clock;

  int total = 0;
  int bad = 0;
  int exp_tx = 0;
  int exp_drop = 0;
  logic [7:0] exp_q[$];

  // Core model: busy for core_len cycles after each start pulse.
  int busy_left = 0;
  int core_len = 10;
  logic hold_busy = 1'b0;
  logic no_busy = 1'b0;

  always @(negedge fpga_clock) begin
    if (tx_start && !no_busy) busy_left = core_len;
    tx_busy = hold_busy || (busy_left > 0);
    if (busy_left > 0) busy_left = busy_left - 1;
  end

  // Scoreboard: every start pulse must match the oldest expected byte.
  always @(negedge fpga_clock) begin
    if (reset && tx_start) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tx got=%02h required=none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          bad++;
          $display("FAIL tx_order got=%02h required=%02h", tx_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge fpga_clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic ferr, input logic en);
    rx_data = d;
    rx_frame_err = ferr;
    echo_en = en;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_frame_err = 1'b0;
    echo_en = 1'b1;
  endtask

  task automatic expect_tx(input logic [7:0] d);
    exp_q.push_back(d);
    exp_tx++;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (20) tick();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       en;
    logic       exp_echo;
    logic       exp_drop;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h41, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h7E, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h33, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hC3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'hA7, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset, then heartbeat period from release.
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_hb", heartbeat, 0);
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("heartbeat", heartbeat, (k / 5) % 2);
    end

    // Single echo latency.
    expect_tx(8'h41);
    send(8'h41, 1'b0, 1'b1);
    chk("echo_n1_count", fifo_count, 1);
    chk("echo_n1_nostart", tx_start, 0);
    tick();
    chk("echo_n2_start", tx_start, 1);
    chk("echo_n2_data", tx_data, 8'h41);
    drain("echo");
    chk("echo_tx_count", tx_count, 1);

    // Reset in WAIT_DONE abandons the byte.
    expect_tx(8'h5A);
    send(8'h5A, 1'b0, 1'b1);
    repeat (5) tick();
    reset = 1'b0;
    tick();
    chk("midrst_start", tx_start, 0);
    chk("midrst_data", tx_data, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_drop", drop_count, 0);
    chk("midrst_txc", tx_count, 0);
    chk("midrst_hb", heartbeat, 0);
    reset = 1'b1;
    busy_left = 0;
    exp_tx = 0;
    exp_drop = 0;
    exp_q.delete();
    repeat (30) tick();
    chk("midrst_txc_after", tx_count, 0);

    // Table of single-byte receive cases.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_echo) expect_tx(vecs[i].data);
      if (vecs[i].exp_drop) exp_drop++;
      send(vecs[i].data, vecs[i].ferr, vecs[i].en);
      drain("vec");
      chk("vec_drop", drop_count, exp_drop);
      chk("vec_txc", tx_count, exp_tx % 16);
      chk("vec_fifo", fifo_count, 0);
    end

    // Core never raises busy: timeout counts as sent.
    no_busy = 1'b1;
    expect_tx(8'h99);
    send(8'h99, 1'b0, 1'b1);
    drain("timeout");
    chk("timeout_txc", tx_count, exp_tx % 16);
    no_busy = 1'b0;

    // Order and overflow: 01 goes to START, 02..05 fill, 06 dropped.
    hold_busy = 1'b1;
    repeat (2) tick();
    for (int b = 1; b <= 5; b++) expect_tx(8'(b));
    exp_drop++;
    for (int b = 1; b <= 6; b++) send(8'(b), 1'b0, 1'b1);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, exp_drop);
    hold_busy = 1'b0;
    drain("ovf");
    chk("ovf_sticky", overflow, 1);
    chk("ovf_txc", tx_count, exp_tx % 16);

    // Beacon waits behind queued echo data.
    hold_busy = 1'b1;
    repeat (2) tick();
    expect_tx(8'h11);
    expect_tx(8'h55);
    expect_tx(8'hA7);
    send(8'h11, 1'b0, 1'b1);
    send(8'h55, 1'b0, 1'b1);
    beacon_en = 1'b1;
    repeat (25) tick();
    beacon_en = 1'b0;
    chk("beacon_fifo", fifo_count, 1);
    hold_busy = 1'b0;
    drain("beacon");
    repeat (60) tick();
    chk("beacon_txc", tx_count, exp_tx % 16);

    // drop_count saturates.
    for (int i = 0; i < 20; i++) send(8'hE0, 1'b1, 1'b1);
    tick();
    chk("drop_sat", drop_count, 15);

    // tx_count wraps.
    for (int i = 0; i < 5; i++) begin
      expect_tx(8'(8'h20 + i));
      send(8'(8'h20 + i), 1'b0, 1'b1);
      drain("wrap");
    end
    chk("txc_wrap", tx_count, exp_tx % 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_echo_buffered.md
# uart_echo_buffered

Parametrised UART echo/beacon controller placed between the board-level UART core and the miner-side logic. Received bytes are pushed into a FIFO and retransmitted in order, and a programmable beacon byte is injected periodically when the link is idle. Frame-error and overflow statistics are kept, and a heartbeat LED output is driven. The block does not instantiate the UART core; it drives the core's transmit handshake and consumes its receive strobe.

## Interface
- `DATA_W`, 8: UART character width.
- `DEPTH`, 16: echo FIFO depth, power of two, ≥2.
- `BEACON_BYTE`, 8'hA7: byte sent on each beacon tick.
- `BEACON_PERIOD`, 250_000_000: clocks between beacon ticks (≥2).
- `HB_DIV`, 50_000_000: clocks per heartbeat LED toggle (≥1).
- `CNT_W`, 16: width of statistic counters.

- `fpga_clock` in 1: sole clock.
- `reset` in 1: synchronous, active-low.
- `echo_en` in 1: 1 = push received bytes to the FIFO.
- `beacon_en` in 1: 1 = beacon ticks are honoured.
- `rx_valid` in 1: one-cycle strobe from the core; a byte is available.
- `rx_data` in DATA_W: received byte, valid with `rx_valid`.
- `rx_frame_err` in 1: framing error, qualified by `rx_valid`.
- `tx_busy` in 1: core transmitter busy.
- `tx_start` out 1: one-cycle start pulse to the core.
- `tx_data` out DATA_W: byte to send; held stable from `tx_start` until `tx_busy` falls.
- `fifo_count` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.
- `drop_count` out CNT_W: count of bytes dropped for overflow and frame errors, saturating.
- `tx_count` out CNT_W: count of bytes transmitted, wrapping.
- `heartbeat` out 1: LED toggle output.

## Operation
- Reset (`reset`=0 at the clock edge): FIFO emptied. `tx_start`, `tx_data`, `fifo_count`, `overflow`, `drop_count`, `tx_count`, and `heartbeat` are all set to 0. The beacon and heartbeat counters are cleared, the pending beacon is cleared, and the FSM enters IDLE. Reset asserted during a transfer abandons the transfer immediately; the in-flight byte is not retried.
- Receive path: on `rx_valid`=1 with `echo_en`=1:
  - `rx_frame_err`=1: the byte is discarded and `drop_count` increments.
  - Otherwise, if the FIFO is not full, the byte is pushed.
  - Otherwise, the byte is dropped, `overflow` is set, and `drop_count` increments.
  - With `echo_en`=0, `rx_valid` is ignored entirely and no counters change.
- Push on a full FIFO in the same cycle as a pop is accepted, with no drop.
- Beacon: a counter counts 0..BEACON_PERIOD-1. On wrap, if `beacon_en`=1, it sets `beacon_pending`. Multiple wraps collapse into one pending beacon.
- TX FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - IDLE: if the FIFO is non-empty, pop the head into `tx_data` and go to START. Else if `beacon_pending`, load BEACON_BYTE, clear pending, and go to START. The echo FIFO always has priority over the beacon.
  - START: `tx_start`=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: wait for `tx_busy`=1, then go to WAIT_DONE. If `tx_busy` is not seen within 4 cycles, treat it as done.
  - WAIT_DONE: on `tx_busy`=0, increment `tx_count` and return to IDLE.
- Counters: `drop_count` saturates at all-ones. `tx_count` wraps modulo 2^CNT_W.
- Heartbeat: toggles every HB_DIV clocks, independent of all other logic.

## Timing
- A push is visible in `fifo_count` one cycle after the `rx_valid` edge.
- Echo latency, measured from `rx_valid` in cycle N with the FSM in IDLE and the FIFO empty:
  - Cycle N+1: FIFO non-empty.
  - Cycle N+2: FSM in START, `tx_start`=1, `tx_data`=byte.
- Back-to-back throughput is limited by the core. The next `tx_start` occurs no earlier than 2 cycles after `tx_busy` falls.
- Simultaneous beacon wrap and `rx_valid` in IDLE: the echo byte is sent first, and the beacon remains pending.
- `tx_start` never asserts while the FSM is outside START.

## Structure
- Shared package `uart_pkg` holds:
  - the TX FSM state enum;
  - `UART_DATA_W` = 8;
  - the default beacon byte 8'hA7.
- Sub-module `sync_fifo`:
  - parameters DATA_W and DEPTH;
  - first-word-fall-through;
  - ports: push, pop, din, dout, full, empty, count.
- Counters, the beacon tick, the heartbeat, and the FSM live in the top module.

## Test plan
- Reset mid-transfer: assert `reset`=0 during WAIT_DONE → the next cycle shows all outputs at 0 and the FSM in IDLE, and no `tx_start` follows until new stimulus.
- Single echo: `rx_valid` with 8'h41, model core busy for 10 cycles → `tx_start` 2 cycles later with `tx_data`=8'h41, and `tx_count`=1 after `tx_busy` falls.
- Order and overflow with DEPTH=4: hold `tx_busy`=1 and push 8'h01..8'h06.
  - During the pushes: `fifo_count`=4, `overflow`=1, `drop_count`=1.
  - After the STARTed byte is consumed by the pop, the transmitted order is 01,02,03,04,05 and 06 is dropped. Precisely, 01 is popped into START, so 02..05 fill the FIFO.
- Frame error: `rx_valid` with `rx_frame_err`=1 → no push, `drop_count`+1, no `tx_start`.
- Beacon priority with BEACON_PERIOD=20: FIFO holds 8'h55 at the beacon tick → 8'h55 is transmitted and then 8'hA7. With `beacon_en`=0, no 8'hA7 ever appears.
- Heartbeat with HB_DIV=5: `heartbeat` toggles every 5 clocks from reset release.
